// File: rtl/boot_mem.sv
// Boot RAM with a byte-stream loader: the loader fills the RAM while the processor is held in reset,
// then ownership passes to the processor. Optional MMIO output register at the top address: BOOT_MEM_MMIO_EN.
module boot_mem #(
  parameter int WIDTH   = 8,
  parameter int ADRBITS = 8,
  parameter int LOADLEN = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ld_valid,
  input  logic [WIDTH-1:0]   ld_data,
  input  logic               ld_last,
  output logic               ld_ready,
  output logic               cpu_reset,
  output logic               done,
  output logic [WIDTH-1:0]   chk,
  input  logic               memread,
  input  logic               memwrite,
  input  logic [ADRBITS-1:0] adr,
  input  logic [WIDTH-1:0]   writedata,
  output logic [WIDTH-1:0]   memdata,
  output logic [WIDTH-1:0]   outport
);

  localparam logic LOAD = 1'b0;
  localparam logic RUN  = 1'b1;

  // One extra bit so the pointer can count to LOADLEN without wrapping when LOADLEN == depth.
  localparam logic [ADRBITS:0]   LAST_PTR = (ADRBITS+1)'(LOADLEN - 1);
  localparam logic [ADRBITS-1:0] TOP_ADR  = '1;

  logic               state;
  logic [ADRBITS:0]   ptr;
  logic [WIDTH-1:0]   mem [0:(1<<ADRBITS)-1];
  logic               ld_acc;
  logic               cpu_wr;
  logic               mmio_hit;

  assign ld_ready = (state == LOAD);
  assign done     = (state == RUN);
  assign ld_acc   = (state == LOAD) && ld_valid && !reset;
  assign cpu_wr   = (state == RUN) && memwrite && !reset;

`ifdef BOOT_MEM_MMIO_EN
  assign mmio_hit = (adr == TOP_ADR);

  always_ff @(posedge clk) begin
    if (reset)                  outport <= '0;
    else if (cpu_wr && mmio_hit) outport <= writedata;
  end
`else
  assign mmio_hit = 1'b0;
  assign outport  = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LOAD;
      ptr       <= '0;
      chk       <= '0;
      cpu_reset <= 1'b1;
    end else begin
      // Lags the state by one cycle so the core sees a reset edge after the final byte lands.
      cpu_reset <= (state == LOAD);
      if (ld_acc) begin
        ptr <= ptr + 1'b1;
        chk <= chk + ld_data;
        if (ld_last || ptr == LAST_PTR) state <= RUN;
      end
    end
  end

  // RAM is never cleared so a reload only overwrites the bytes it streams.
  always_ff @(posedge clk) begin
    if (ld_acc)                    mem[ptr[ADRBITS-1:0]] <= ld_data;
    else if (cpu_wr && !mmio_hit)  mem[adr]              <= writedata;
  end

  always_comb begin
    memdata = '0;
    if (state == RUN && memread) memdata = mmio_hit ? outport : mem[adr];
  end

endmodule

// File: tb/tb_boot_mem.sv
// Scoreboard bench for boot_mem: a default instance and a LOADLEN=4 instance, directed vectors.
module tb_boot_mem;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic       reset, ld_valid, ld_last, memread, memwrite;
  logic [7:0] ld_data, adr, writedata;
  logic       ld_ready, cpu_reset, done;
  logic [7:0] chk, memdata, outport;

  // LOADLEN=4 instance
  logic       b_reset, b_ld_valid, b_ld_last, b_memread, b_memwrite;
  logic [7:0] b_ld_data, b_adr, b_writedata;
  logic       b_ld_ready, b_cpu_reset, b_done;
  logic [7:0] b_chk, b_memdata, b_outport;

  boot_mem u0 (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .cpu_reset(cpu_reset), .done(done), .chk(chk),
    .memread(memread), .memwrite(memwrite), .adr(adr), .writedata(writedata),
    .memdata(memdata), .outport(outport)
  );

  boot_mem #(.LOADLEN(4)) u1 (
    .clk(clk), .reset(b_reset), .ld_valid(b_ld_valid), .ld_data(b_ld_data), .ld_last(b_ld_last),
    .ld_ready(b_ld_ready), .cpu_reset(b_cpu_reset), .done(b_done), .chk(b_chk),
    .memread(b_memread), .memwrite(b_memwrite), .adr(b_adr), .writedata(b_writedata),
    .memdata(b_memdata), .outport(b_outport)
  );

  localparam int MD0 = 0, DN0 = 1, CR0 = 2, RDY0 = 3, CK0 = 4, OP0 = 5;
  localparam int MD1 = 6, DN1 = 7, RDY1 = 8, CK1 = 9, CR1 = 10;

  typedef struct {
    int         cyc;
    int         id;
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_mis = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] act(int id);
    case (id)
      MD0:  return memdata;
      DN0:  return {7'd0, done};
      CR0:  return {7'd0, cpu_reset};
      RDY0: return {7'd0, ld_ready};
      CK0:  return chk;
      OP0:  return outport;
      MD1:  return b_memdata;
      DN1:  return {7'd0, b_done};
      RDY1: return {7'd0, b_ld_ready};
      CK1:  return b_chk;
      CR1:  return {7'd0, b_cpu_reset};
      default: return 8'hxx;
    endcase
  endfunction

  // Monitor: compares every expectation due in the current cycle, away from the rising edge.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      n_cmp++;
      if (act(e.id) !== e.val) begin
        n_mis++;
        $display("FAIL %s: got %h want %h (cycle %0d)", e.name, act(e.id), e.val, cyc);
      end
    end
  end

  task automatic expect_v(int id, logic [7:0] v, string nm);
    exp_t x;
    x.cyc = cyc; x.id = id; x.val = v; x.name = nm;
    q.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ld0(logic [7:0] d, logic last);
    ld_valid = 1'b1; ld_data = d; ld_last = last;
    step();
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic wr0(logic [7:0] a, logic [7:0] d);
    memwrite = 1'b1; memread = 1'b0; adr = a; writedata = d;
    step();
    memwrite = 1'b0;
  endtask

  task automatic rd0(logic [7:0] a, logic [7:0] v, string nm);
    memread = 1'b1; adr = a;
    expect_v(MD0, v, nm);
    step();
  endtask

  task automatic ld1(logic [7:0] d, logic last);
    b_ld_valid = 1'b1; b_ld_data = d; b_ld_last = last;
    step();
    b_ld_valid = 1'b0; b_ld_last = 1'b0;
  endtask

  task automatic rd1(logic [7:0] a, logic [7:0] v, string nm);
    b_memread = 1'b1; b_adr = a;
    expect_v(MD1, v, nm);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] sum;
    reset = 1; ld_valid = 1; ld_data = 8'h77; ld_last = 0;
    memread = 1; memwrite = 0; adr = 0; writedata = 0;
    b_reset = 1; b_ld_valid = 0; b_ld_data = 0; b_ld_last = 0;
    b_memread = 0; b_memwrite = 0; b_adr = 0; b_writedata = 0;
    repeat (2) step();
    reset = 0; ld_valid = 0;
    expect_v(DN0, 0, "rst_done");
    expect_v(CR0, 1, "rst_cpu_reset");
    expect_v(RDY0, 1, "rst_ld_ready");
    expect_v(CK0, 8'h00, "rst_chk");
    expect_v(OP0, 8'h00, "rst_outport");
    expect_v(MD0, 8'h00, "load_memdata_zero");

    // Basic stream with an idle ld_last-only cycle in the middle
    ld0(8'h11, 0);
    expect_v(CK0, 8'h11, "chk_after_1");
    ld_last = 1; step(); ld_last = 0;
    expect_v(CK0, 8'h11, "chk_idle_last");
    expect_v(DN0, 0, "done_idle_last");
    ld0(8'h22, 0);
    ld0(8'h33, 1);
    expect_v(DN0, 1, "done_after_last");
    expect_v(CR0, 1, "cpu_reset_held");
    expect_v(RDY0, 0, "ready_in_run");
    expect_v(CK0, 8'h66, "chk_66");
    expect_v(MD0, 8'h11, "run_read_adr0");

    // Loader inputs ignored in RUN
    ld_valid = 1; ld_data = 8'h99; ld_last = 1;
    step();
    ld_valid = 0; ld_last = 0;
    expect_v(CR0, 0, "cpu_reset_released");
    expect_v(CK0, 8'h66, "chk_ignores_run_ld");

    rd0(8'h01, 8'h22, "mem1");
    rd0(8'h02, 8'h33, "mem2");

    // Read-during-write returns old data; new value next cycle
    wr0(8'h10, 8'h3C);
    wr0(8'h03, 8'h44);
    memwrite = 1; memread = 1; adr = 8'h10; writedata = 8'hA5;
    expect_v(MD0, 8'h3C, "rdw_old");
    step();
    memwrite = 0;
    expect_v(MD0, 8'hA5, "read_new_A5");
    step();
    memread = 0;
    expect_v(MD0, 8'h00, "memread0_zero");
    step();

    // Top address: output register or ordinary RAM depending on build
    wr0(8'hFF, 8'h5A);
    wr0(8'hFE, 8'h12);
`ifdef BOOT_MEM_MMIO_EN
    expect_v(OP0, 8'h5A, "outport_mmio");
`else
    expect_v(OP0, 8'h00, "outport_tied");
`endif
    rd0(8'hFF, 8'h5A, "read_top");
    rd0(8'hFE, 8'h12, "read_fe");

    // Reset during RUN, then reload two bytes; byte under reset must not land
    memread = 0;
    reset = 1; ld_valid = 1; ld_data = 8'h55;
    step();
    reset = 0; ld_valid = 0;
    expect_v(DN0, 0, "rerst_done");
    expect_v(CR0, 1, "rerst_cpu_reset");
    expect_v(CK0, 8'h00, "rerst_chk");
    expect_v(OP0, 8'h00, "rerst_outport");
    ld0(8'h01, 0);
    expect_v(CR0, 1, "reload_cpu_reset1");
    ld0(8'h02, 1);
    expect_v(CK0, 8'h03, "reload_chk");
    expect_v(CR0, 1, "reload_cpu_reset2");
    expect_v(DN0, 1, "reload_done");
    step();
    expect_v(CR0, 0, "reload_cpu_released");
    rd0(8'h00, 8'h01, "reload_mem0");
    rd0(8'h01, 8'h02, "reload_mem1");
    rd0(8'h02, 8'h33, "kept_mem2");
    rd0(8'h03, 8'h44, "kept_mem3");
    rd0(8'h10, 8'hA5, "kept_mem10");
    memread = 0;

    // LOADLEN=4 instance: seed mem[4], then overflow the loader
    b_reset = 0;
    ld1(8'hAA, 1);
    expect_v(DN1, 1, "b_done_single");
    b_memwrite = 1; b_adr = 8'h04; b_writedata = 8'hEE;
    step();
    b_memwrite = 0;
    b_reset = 1; step(); b_reset = 0;
    expect_v(DN1, 0, "b_rst_done");
    expect_v(RDY1, 1, "b_rst_ready");
    expect_v(CK1, 8'h00, "b_rst_chk");
    sum = 0;
    for (int i = 1; i <= 6; i++) begin
      b_ld_valid = 1; b_ld_data = 8'(i);
      step();
      if (i <= 4) sum = sum + 8'(i);
      expect_v(RDY1, (i < 4) ? 8'd1 : 8'd0, "b_ready");
      expect_v(DN1, (i >= 4) ? 8'd1 : 8'd0, "b_done");
      expect_v(CK1, sum, "b_chk");
    end
    b_ld_valid = 0;
    expect_v(CR1, 0, "b_cpu_reset_released");
    rd1(8'h04, 8'hEE, "b_mem4_kept");
    rd1(8'h03, 8'h04, "b_mem3");
    rd1(8'h00, 8'h01, "b_mem0");
    b_memread = 0;

    repeat (3) step();
    if (q.size() != 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
